// File: rtl/uart_word_pkg.sv
// Shared types and constants for the 64-bit UART word intake/transmit pair.
package uart_word_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } word_tx_state_t;

  localparam int UART_BYTE_W        = 8;
  localparam int WORD_BYTES_DEFAULT = 8;

endpackage

// File: rtl/uart_word64_tx.sv
// Word-to-byte serializer feeding the byte-wide UART TX core.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | word_ready high, waiting for a word handshake
// SEND  | tx_valid high, head byte of shift register presented on tx_data
// DONE  | one-cycle done pulse after the final byte was taken
module uart_word64_tx
  import uart_word_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEFAULT,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [UART_BYTE_W*WORD_BYTES-1:0]   word_in,
  input  logic                                word_valid,
  output logic                                word_ready,
  output logic [UART_BYTE_W-1:0]              tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                busy,
  output logic                                done
);

  localparam int WORD_W = UART_BYTE_W * WORD_BYTES;
  localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

  word_tx_state_t    state;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] shifted;

  // Next shift-register value after a byte is taken; vacated bits fill with zeros.
  always_comb begin
    shifted = MSB_FIRST ? (shift_reg << UART_BYTE_W) : (shift_reg >> UART_BYTE_W);
  end

  // Head byte comes straight from the shift register flops, so it is registered.
  assign tx_data = MSB_FIRST ? shift_reg[WORD_W-1 -: UART_BYTE_W]
                             : shift_reg[UART_BYTE_W-1:0];

  // Sequencer: state, data path and registered handshake outputs updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      word_ready <= 1'b1;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (word_valid) begin
            shift_reg  <= word_in;
            byte_cnt   <= '0;
            state      <= SEND;
            word_ready <= 1'b0;
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_cnt == LAST_IDX) begin
              state    <= DONE;
              tx_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              shift_reg <= shifted;
              byte_cnt  <= byte_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          word_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          word_ready <= 1'b1;
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word64_tx.sv
// Randomized bench for uart_word64_tx: MSB-first and LSB-first instances
// checked against a byte-order model computed from the word value.
module tb_uart_word64_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] word_in = '0;
  logic        word_valid_m = 1'b0;
  logic        word_valid_l = 1'b0;
  logic        tx_ready = 1'b0;

  logic        m_word_ready, m_tx_valid, m_busy, m_done;
  logic [7:0]  m_tx_data;
  logic        l_word_ready, l_tx_valid, l_busy, l_done;
  logic [7:0]  l_tx_data;

  bit          sel = 1'b0;
  logic        o_word_ready, o_tx_valid, o_busy, o_done;
  logic [7:0]  o_tx_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word64_tx #(.WORD_BYTES(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid_m),
    .word_ready(m_word_ready), .tx_data(m_tx_data), .tx_valid(m_tx_valid),
    .tx_ready(tx_ready), .busy(m_busy), .done(m_done)
  );

  uart_word64_tx #(.WORD_BYTES(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid_l),
    .word_ready(l_word_ready), .tx_data(l_tx_data), .tx_valid(l_tx_valid),
    .tx_ready(tx_ready), .busy(l_busy), .done(l_done)
  );

  assign o_word_ready = sel ? l_word_ready : m_word_ready;
  assign o_tx_valid   = sel ? l_tx_valid   : m_tx_valid;
  assign o_tx_data    = sel ? l_tx_data    : m_tx_data;
  assign o_busy       = sel ? l_busy       : m_busy;
  assign o_done       = sel ? l_done       : m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [63:0] w, input int k, input bit lsb);
    if (lsb) return 8'(w >> (8 * k));
    else     return 8'(w >> (8 * (7 - k)));
  endfunction

  task automatic set_valid(input bit v);
    word_valid_m = v & !sel;
    word_valid_l = v & sel;
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random.
  // chain keeps word_valid high with nxt during the word to probe busy-ignore.
  task automatic run_word(input logic [63:0] w, input int mode, input bit chain,
                          input logic [63:0] nxt, output int hs_cyc);
    int t;
    int acc;
    int step;
    bit r;
    logic [7:0] exp_q[8];
    t = 0;
    while (!o_word_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("word_ready_before_hs", o_word_ready, 1);
    chk("busy_idle", o_busy, 0);
    hs_cyc = cyc;
    word_in = w;
    set_valid(1'b1);
    tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_q[k] = model_byte(w, k, sel);
    @(negedge clk);
    if (chain) word_in = nxt;
    else set_valid(1'b0);
    chk("word_ready_sending", o_word_ready, 0);
    acc = 0;
    step = 0;
    while (acc < 8 && step < 200) begin
      chk("tx_valid", o_tx_valid, 1);
      chk("tx_data", o_tx_data, exp_q[acc]);
      chk("done_early", o_done, 0);
      case (mode)
        0: r = 1'b1;
        1: r = (step % 4 == 0) || (step % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      @(negedge clk);
      if (r) acc++;
      step++;
    end
    chk("accepts", acc, 8);
    tx_ready = 1'($urandom_range(0, 1));
    chk("done_pulse", o_done, 1);
    chk("tx_valid_done", o_tx_valid, 0);
    chk("word_ready_done", o_word_ready, 0);
    chk("busy_done", o_busy, 1);
    @(negedge clk);
    chk("done_clear", o_done, 0);
    chk("word_ready_after", o_word_ready, 1);
    chk("busy_after", o_busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_word_ready"}, o_word_ready, 1);
    chk({tag, "_tx_valid"}, o_tx_valid, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    int h1, h2, hx;
    logic [63:0] w;

    repeat (2) @(negedge clk);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // Basic and back-pressured word, MSB first.
    sel = 1'b0;
    run_word(64'h0123456789ABCDEF, 0, 1'b0, 64'h0, hx);
    run_word(64'h0123456789ABCDEF, 1, 1'b0, 64'h0, hx);

    // Word offered while busy is ignored, then accepted back-to-back.
    w = {$urandom, $urandom};
    run_word(w, 0, 1'b1, 64'hFFFF_0000_AAAA_5555, h1);
    run_word(64'hFFFF_0000_AAAA_5555, 0, 1'b0, 64'h0, h2);
    chk("word_period", h2 - h1, 10);

    // Reset in the middle of a word.
    word_in = 64'hDEAD_BEEF_CAFE_F00D;
    set_valid(1'b1);
    @(negedge clk);
    set_valid(1'b0);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("pre_reset_byte", o_tx_data, model_byte(64'hDEAD_BEEF_CAFE_F00D, k, 1'b0));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_word_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_mid_reset");
    run_word(64'h1122334455667788, 0, 1'b0, 64'h0, hx);

    // LSB-first instance.
    sel = 1'b1;
    run_word(64'h0123456789ABCDEF, 0, 1'b0, 64'h0, hx);
    run_word(64'h0123456789ABCDEF, 1, 1'b0, 64'h0, hx);

    // Random words under random back-pressure on both instances.
    for (int i = 0; i < 12; i++) begin
      sel = i[0];
      w = {$urandom, $urandom};
      run_word(w, 2, 1'b0, 64'h0, hx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_word64_tx.md
# uart_word64_tx

Serializes a 64-bit data word into eight bytes for the UART transmitter, the transmit-side counterpart of the 64-bit byte-assembling intake. It sits between word-producing logic (the result path of the degree-project datapath) and the byte-wide UART TX core. It accepts one word per valid/ready handshake, presents bytes one at a time on a byte-side valid/ready handshake, and pulses a done flag when the last byte has been taken.

## Interface
- `WORD_BYTES`, default 8: bytes per word. The word width is `8*WORD_BYTES`.
- `MSB_FIRST`, default 1: 1 sends byte `[63:56]` first, which matches the intake's shift-left assembly order; 0 sends byte `[7:0]` first.

Ports:
- `clk` input, 1: system clock. All logic is in this single clock domain.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `word_in` input, 64: word to send. It is sampled only on the word handshake.
- `word_valid` input, 1: `word_in` is valid.
- `word_ready` output, 1: the block is idle and can accept a word.
- `tx_data` output, 8: current byte for the UART TX core.
- `tx_valid` output, 1: `tx_data` is valid and held stable until accepted.
- `tx_ready` input, 1: the UART TX core accepts `tx_data` in this cycle.
- `busy` output, 1: a word is in progress.
- `done` output, 1: one-cycle pulse after the final byte is accepted.

## Operation
- States: `IDLE`, `SEND`, `DONE`.
- `IDLE`
  - `word_ready`=1.
  - On `word_valid && word_ready`, load `word_in` into the shift register, set the byte counter to 0, and go to `SEND`.
- `SEND`
  - `tx_valid`=1 and `tx_data` = current head byte of the shift register.
  - On `tx_valid && tx_ready`: shift the register by 8 bits (left if `MSB_FIRST`, else right) and increment the counter.
  - If the counter was `WORD_BYTES-1`, go to `DONE` instead of shifting.
  - With `tx_ready`=0, state, `tx_data` and the counter hold.
- `DONE`
  - `done`=1 for exactly one cycle, then go to `IDLE`.
  - `tx_valid`=0 and `word_ready`=0.
- `busy` = (state != `IDLE`).
- `word_valid` while `busy`=1 is ignored. No queuing; the producer must hold the word until `word_ready`.
- Counter width is `$clog2(WORD_BYTES)`, with no wrap-around past `WORD_BYTES-1`.
- The shift register fills with zeros, so a stale byte never re-appears.
- Reset, asynchronous at any time including mid-word:
  - state → `IDLE`; shift register and counter → 0.
  - The partial word is discarded and not resumed.

## Timing
Reset values:
- `word_ready`=1 once reset is deasserted.
- `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0.

Latency:
- Word handshake in cycle N gives `tx_valid`=1 with the first byte in cycle N+1.
- Byte k accepted in cycle M gives byte k+1 on `tx_data` in cycle M+1, with `tx_valid` staying high (no bubble).
- Last byte accepted in cycle L: `done`=1 in L+1, and `word_ready`=1 in L+2.
- Minimum word period is `WORD_BYTES`+2 cycles when `tx_ready` is held high.

Handshake rules:
- `tx_valid` never deasserts before acceptance.
- `tx_data` never changes while `tx_valid && !tx_ready`.
- All outputs are registered; there is no combinational path from `tx_ready` or `word_valid` to any output.

## Structure
- Package `uart_word_pkg`:
  - state enum `word_tx_state_t` (`IDLE`, `SEND`, `DONE`);
  - constant `UART_BYTE_W`=8;
  - constant `WORD_BYTES_DEFAULT`=8.
  - The intake block shares this package.
- No sub-module. There is one FSM, one shift register and one counter in a single module.

## Test plan
- **Basic word:** `word_in`=64'h0123456789ABCDEF, `tx_ready` held 1 → `tx_data` sequence 01,23,45,67,89,AB,CD,EF on consecutive cycles, then `done` pulses once, then `word_ready`=1.
- **Back-pressure:** same word, `tx_ready` toggling 1,0,0,1,… → each byte is held stable while `tx_ready`=0, the byte order is unchanged, and there are exactly 8 acceptances.
- **Busy and back-to-back:** `word_valid` asserted with 64'hFFFF_0000_AAAA_5555 during a word → ignored until `word_ready`. Then it is accepted with a period of 10 cycles and bytes FF,FF,00,00,AA,AA,55,55.
- **Reset mid-word:** `rst_n` low after byte 3 is accepted → all outputs return to their reset values immediately. The next word 64'h1122334455667788 sends 11..88 in full.
- **LSB first:** `MSB_FIRST`=0 with 64'h0123456789ABCDEF → EF,CD,AB,89,67,45,23,01.
